// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - size/state encodings, lane constants and alignment helper for the LSU
package load_store_unit_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_READ  = 2'b01;
    localparam logic [1:0] ST_WRITE = 2'b10;
    localparam logic [1:0] ST_RESP  = 2'b11;

    localparam int          LANE_W    = 8;
    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

    // Illegal size is folded in so one test covers every error response.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = offset[0];
            SIZE_W:  misaligned = (offset != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extract/extend and sub-word store lane merge
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] rd,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] mask;

    assign sh = {offset, 3'b000};

    always_comb begin
        shifted = rd >> sh;
        case (size)
            SIZE_B:  load_data = is_unsigned ? {24'b0, shifted[LANE_W-1:0]}
                                             : {{24{shifted[7]}}, shifted[LANE_W-1:0]};
            SIZE_H:  load_data = is_unsigned ? {16'b0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // A word access gets an all-ones mask, so merged equals wdata for word stores.
    always_comb begin
        case (size)
            SIZE_B:  mask = BYTE_MASK << sh;
            SIZE_H:  mask = HALF_MASK << sh;
            default: mask = '1;
        endcase
        merged = (rd & ~mask) | ((wdata << sh) & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator FSM; sub-word access built only with LSU_SUBWORD_EN
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    logic [1:0]        state;
    logic              l_we;
    logic [ADDR_W-3:0] l_word;
    logic [DATA_W-1:0] l_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              bad;
    logic              new_read;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wd_word;

`ifdef LSU_SUBWORD_EN
    logic [1:0]        l_size;
    logic [1:0]        l_off;
    logic              l_uns;
    logic [DATA_W-1:0] cap_q;
    logic [DATA_W-1:0] align_rd;

    // Loads extract straight from mem_rd in READ; the store merge uses the captured word in WRITE.
    assign align_rd = (state == ST_READ) ? mem_rd : cap_q;

    lsu_align u_align (
        .size        (l_size),
        .is_unsigned (l_uns),
        .offset      (l_off),
        .rd          (align_rd),
        .wdata       (l_wdata),
        .load_data   (load_data),
        .merged      (wd_word)
    );

    assign bad      = misaligned(req_size, req_addr[1:0]);
    assign new_read = !req_we || (req_size != SIZE_W);
`else
    logic unused_cfg;

    assign unused_cfg = ^{req_size, req_unsigned};
    assign bad        = (req_addr[1:0] != 2'b00);
    assign new_read   = !req_we;
    assign load_data  = mem_rd;
    assign wd_word    = l_wdata;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            l_we    <= 1'b0;
            l_word  <= '0;
            l_wdata <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef LSU_SUBWORD_EN
            l_size  <= SIZE_W;
            l_off   <= 2'b00;
            l_uns   <= 1'b0;
            cap_q   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        l_we    <= req_we;
                        l_word  <= req_addr[ADDR_W-1:2];
                        l_wdata <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= bad;
`ifdef LSU_SUBWORD_EN
                        l_size  <= req_size;
                        l_off   <= req_addr[1:0];
                        l_uns   <= req_unsigned;
`endif
                        if (bad)
                            state <= ST_RESP;
                        else if (new_read)
                            state <= ST_READ;
                        else
                            state <= ST_WRITE;
                    end
                end
                ST_READ: begin
`ifdef LSU_SUBWORD_EN
                    cap_q <= mem_rd;
`endif
                    if (l_we) begin
                        state <= ST_WRITE;
                    end else begin
                        rdata_q <= load_data;
                        state   <= ST_RESP;
                    end
                end
                ST_WRITE: state <= ST_RESP;
                ST_RESP:  if (rsp_ready) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Gating with rst keeps req_ready low while reset is held, not just after it.
    assign req_ready = (state == ST_IDLE) && rst;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = (state == ST_RESP) ? rdata_q : '0;
    assign rsp_err   = (state == ST_RESP) && err_q;
    assign mem_we    = (state == ST_WRITE);
    assign mem_a     = (state == ST_READ || state == ST_WRITE) ? {2'b00, l_word} : '0;
    assign mem_wd    = (state == ST_WRITE) ? wd_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - LSU plus 1024-word data memory against a byte-level reference model
module tb_load_store_unit;

`ifdef LSU_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] dmem    [1024];
    logic [31:0] ref_mem [1024];
    int          we_count = 0;
    logic [31:0] last_we_a = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    assign mem_rd = dmem[mem_a[9:0]];

    always @(posedge clk) begin
        if (mem_we) begin
            dmem[mem_a[9:0]] <= mem_wd;
            we_count         <= we_count + 1;
            last_we_a        <= mem_a;
        end
    end

    // Memory seen as little-endian bytes; an access is nbytes consecutive bytes from addr.
    function automatic void model(input bit we, input logic [1:0] size, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output bit err, output logic [31:0] rdata,
                                  output int lat, output int nwr);
        int nbytes;
        int a;
        logic [31:0] val;
        logic [31:0] ones;
        ones = '1;
        if (!SUBWORD)           nbytes = 4;
        else if (size == 2'b00) nbytes = 1;
        else if (size == 2'b01) nbytes = 2;
        else if (size == 2'b10) nbytes = 4;
        else                    nbytes = 0;
        err   = (nbytes == 0) ? 1'b1 : ((int'(addr[11:0]) % nbytes) != 0);
        rdata = '0;
        nwr   = 0;
        lat   = 1;
        if (err) return;
        val = '0;
        for (int b = 0; b < nbytes; b++) begin
            a = int'(addr[11:0]) + b;
            if (we) ref_mem[a / 4][8 * (a % 4) +: 8] = wdata[8 * b +: 8];
            else    val[8 * b +: 8] = ref_mem[a / 4][8 * (a % 4) +: 8];
        end
        if (!we && nbytes < 4 && !uns && val[8 * nbytes - 1])
            val = val | (ones << (8 * nbytes));
        if (we) begin
            nwr = 1;
            lat = (nbytes < 4) ? 3 : 2;
        end else begin
            rdata = val;
            lat   = 2;
        end
    endfunction

    task automatic run_req(input string name, input bit we, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat, exp_wr, lat, wc0;
        model(we, size, uns, addr, wdata, exp_err, exp_rdata, exp_lat, exp_wr);
        @(negedge clk);
        rsp_ready    = (hold == 0);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready_idle: got %b expected 1", name, req_ready);
        end
        wc0 = we_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 8) begin
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s req_ready_busy: got %b expected 0", name, req_ready);
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (rsp_err !== exp_err) begin
            errors++;
            $display("FAIL %s rsp_err: got %b expected %b", name, rsp_err, exp_err);
        end
        checks++;
        if (rsp_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL %s rsp_rdata: got %h expected %h", name, rsp_rdata, exp_rdata);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: got valid=%b rdata=%h err=%b ready=%b expected 1 %h %b 0",
                         name, i, rsp_valid, rsp_rdata, rsp_err, req_ready, exp_rdata, exp_err);
            end
        end
        if (hold > 0) begin
            @(negedge clk);
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s back_to_idle: got valid=%b ready=%b expected 0 1", name, rsp_valid, req_ready);
        end
        checks++;
        if (we_count - wc0 != exp_wr) begin
            errors++;
            $display("FAIL %s write_count: got %0d expected %0d", name, we_count - wc0, exp_wr);
        end
        if (exp_wr > 0) begin
            checks++;
            if (last_we_a !== {2'b00, addr[31:2]}) begin
                errors++;
                $display("FAIL %s mem_a: got %h expected %h", name, last_we_a, {2'b00, addr[31:2]});
            end
        end
        checks++;
        if (dmem[addr[11:2]] !== ref_mem[addr[11:2]]) begin
            errors++;
            $display("FAIL %s mem_word: got %h expected %h", name, dmem[addr[11:2]], ref_mem[addr[11:2]]);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_we !== 1'b0 || mem_a !== 32'h0 ||
            mem_wd !== 32'h0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b we=%b a=%h wd=%h rd=%h err=%b expected all 0",
                     req_ready, rsp_valid, mem_we, mem_a, mem_wd, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] exp_word;
        run_req("word_store", 1'b1, 2'b10, 1'b0, 32'hA8, 32'hDEADBEEF, 0);
        checks++;
        if (dmem[42] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_store_mem: got %h expected deadbeef", dmem[42]);
        end
        run_req("word_load", 1'b0, 2'b10, 1'b0, 32'hA8, 32'h0, 0);
        run_req("byte_store", 1'b1, 2'b00, 1'b0, 32'hA9, 32'h0000007F, 0);
        exp_word = SUBWORD ? 32'hDEAD7FEF : 32'hDEADBEEF;
        checks++;
        if (dmem[42] !== exp_word) begin
            errors++;
            $display("FAIL byte_store_mem: got %h expected %h", dmem[42], exp_word);
        end
        run_req("byte_load_s", 1'b0, 2'b00, 1'b0, 32'hA8, 32'h0, 0);
        run_req("byte_load_u", 1'b0, 2'b00, 1'b1, 32'hA8, 32'h0, 0);
        run_req("half_load_s", 1'b0, 2'b01, 1'b0, 32'hAA, 32'h0, 0);
        run_req("half_load_u", 1'b0, 2'b01, 1'b1, 32'hAA, 32'h0, 0);
        run_req("half_misalign", 1'b0, 2'b01, 1'b0, 32'hA9, 32'h0, 0);
        run_req("size_illegal", 1'b1, 2'b11, 1'b0, 32'hA8, 32'h12345678, 0);
        run_req("word_misalign_st", 1'b1, 2'b10, 1'b0, 32'hAA, 32'h55555555, 0);
    endtask

    task automatic test_backpressure();
        run_req("load_hold5", 1'b0, 2'b10, 1'b0, 32'hA8, 32'h0, 5);
        run_req("store_hold3", 1'b1, 2'b01, 1'b0, 32'h1C2, 32'hCAFE1234, 3);
    endtask

    task automatic test_random();
        logic [1:0]  size;
        logic [31:0] addr;
        int          r;
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            size = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 9) < 7) addr[1:0] = 2'b00;
            run_req("random", 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)),
                    addr, $urandom, $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_in_write();
        int n;
        @(negedge clk);
        rsp_ready    = 1'b1;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h40;
        req_wdata    = 32'h11223344;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (mem_we !== 1'b1 && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_write_reach: got mem_we=%b expected 1", mem_we);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || req_ready !== 1'b0 || mem_a !== 32'h0) begin
            errors++;
            $display("FAIL rst_write_drop: got we=%b ready=%b a=%h expected 0 0 0", mem_we, req_ready, mem_a);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_write_release: got ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
        end
        checks++;
        if (dmem[16] !== ref_mem[16]) begin
            errors++;
            $display("FAIL rst_write_mem: got %h expected %h", dmem[16], ref_mem[16]);
        end
        run_req("post_reset_load", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);
    endtask

    initial begin
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            dmem[i]    = $urandom;
            ref_mem[i] = dmem[i];
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_in_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
